// File: rtl/rand_arb_pkg.sv
// -----------------------------------------------------------------------------
// rand_arb_pkg
// Shared definitions for the rand_arbiter block:
//   NREQ_MAX    - largest supported requester count
//   state_e     - arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   WHITEN_ROT  - left-rotate amount used by the optional output whitening
//   rotl_whiten - rotate helper used when RAND_ARB_WHITEN_EN is defined
// -----------------------------------------------------------------------------
package rand_arb_pkg;

    localparam int NREQ_MAX   = 8;
    localparam int WHITEN_ROT = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [31:0] rotl_whiten(input logic [31:0] v);
        return (v << WHITEN_ROT) | (v >> (32 - WHITEN_ROT));
    endfunction

endpackage

// File: rtl/rand_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Scans req starting at index ptr,
// wrapping from NREQ-1 back to 0, and reports the first set bit.
// Ports:
//   req_i [NREQ-1:0]   request vector
//   ptr_i [IDX_W-1:0]  index with highest priority this cycle
//   sel_o [NREQ-1:0]   one-hot winner (zero when nothing requested)
//   idx_o [IDX_W-1:0]  binary index of the winner
//   any_o              at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import rand_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  sel_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        sel_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Candidate index walks ptr, ptr+1, ... modulo NREQ.
            cand = int'(ptr_i) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                sel_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// -----------------------------------------------------------------------------
// rand_arbiter
// Shares one free-running random sample stream among NREQ requesters. Each
// grant delivers the current sample; a sample already handed out is never
// delivered twice in a row (the arbiter stalls instead). Two-state FSM: a
// grant is followed by one mandatory idle cycle, so at most one grant per
// two clocks.
// Optional build macro: RAND_ARB_WHITEN_EN - when defined, rand_out is the
// raw sample XOR the previous rand_out rotated left by WHITEN_ROT.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester level request, held until granted
//   rand_in    free-running 32-bit sample
//   gnt        registered one-hot grant pulse
//   rand_out   registered sample delivered with gnt
//   rand_valid high exactly when gnt is non-zero
//   stall      registered; a grant was blocked by a stale sample
// -----------------------------------------------------------------------------
module rand_arbiter
    import rand_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [31:0]     rand_in,
    output logic [NREQ-1:0] gnt,
    output logic [31:0]     rand_out,
    output logic            rand_valid,
    output logic            stall
);

    localparam int IDX_W = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [31:0]       rand_out_q, rand_out_d;
    logic              stall_q, stall_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [31:0]       last_q, last_d;

    logic [NREQ-1:0]   pick_sel;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [31:0]       shaped;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .sel_o (pick_sel),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

`ifdef RAND_ARB_WHITEN_EN
    assign shaped = rand_in ^ rotl_whiten(rand_out_q);
`else
    assign shaped = rand_in;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        rand_out_d = rand_out_q;
        stall_d    = 1'b0;
        ptr_d      = ptr_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // Stale-sample check uses the raw input, never the
                    // whitened value, so repeats of rand_in are caught.
                    if (rand_in != last_q) begin
                        gnt_d      = pick_sel;
                        rand_out_d = shaped;
                        last_d     = rand_in;
                        ptr_d      = (pick_idx == IDX_W'(NREQ - 1)) ? '0
                                                                     : pick_idx + IDX_W'(1);
                        state_d    = GRANT;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                // Requests are ignored here; the requester drops req at the
                // edge that ends its grant cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rand_out_q <= '0;
            stall_q    <= 1'b0;
            ptr_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rand_out_q <= rand_out_d;
            stall_q    <= stall_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
        end
    end

    assign gnt        = gnt_q;
    assign rand_out   = rand_out_q;
    assign rand_valid = |gnt_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_rand_arbiter.sv
module tb_rand_arbiter;

    localparam int NREQ = 4;
`ifdef RAND_ARB_WHITEN_EN
    localparam bit WHITEN = 1'b1;
`else
    localparam bit WHITEN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [31:0]     rand_in;
    logic [NREQ-1:0] gnt;
    logic [31:0]     rand_out;
    logic            rand_valid;
    logic            stall;

    int checks;
    int fails;

    // Reference model state: what has been served, whose turn it is, and
    // whether the previous cycle produced a grant (forcing a rest cycle).
    bit              m_rest;
    int              m_ptr;
    logic [31:0]     m_last;
    logic [NREQ-1:0] exp_gnt;
    logic [31:0]     exp_out;
    logic            exp_stall;

    rand_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rand_in    (rand_in),
        .gnt        (gnt),
        .rand_out   (rand_out),
        .rand_valid (rand_valid),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_rest    = 1'b0;
        m_ptr     = 0;
        m_last    = '0;
        exp_gnt   = '0;
        exp_out   = '0;
        exp_stall = 1'b0;
    endtask

    // Advance one clock; update the model from the inputs seen at the edge,
    // then let DUT outputs settle for 1 time unit.
    task automatic step();
        int win;
        @(posedge clk);
        exp_stall = 1'b0;
        exp_gnt   = '0;
        if (m_rest) begin
            m_rest = 1'b0;
        end else if (req != '0) begin
            if (rand_in == m_last) begin
                exp_stall = 1'b1;
            end else begin
                win = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                end
                exp_gnt = '0;
                exp_gnt[win] = 1'b1;
                if (WHITEN) exp_out = rand_in ^ {exp_out[24:0], exp_out[31:25]};
                else        exp_out = rand_in;
                m_last = rand_in;
                m_ptr  = (win + 1) % NREQ;
                m_rest = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req     = '1;
        rand_in = 32'hDEAD_BEEF;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (rand_out !== 32'h0) begin fails++; $display("FAIL reset_rand_out got %h want 0", rand_out); end
        checks++; if (rand_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rand_valid); end
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        rst_n = 1'b1;
        // rand_in == 0 right after reset matches last_served: no grant, stall.
        req = 4'b0001; rand_in = 32'h0;
        step();
        checks++; if (gnt !== '0 || stall !== 1'b1) begin fails++; $display("FAIL reset_zero_sample gnt=%b stall=%b want 0000/1", gnt, stall); end
        req = '0; rand_in = 32'h5;
        step();
        checks++; if (gnt !== '0 || stall !== 1'b0) begin fails++; $display("FAIL idle_noreq gnt=%b stall=%b want 0000/0", gnt, stall); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010; rand_in = 32'h0000_0011;
        step();
        checks++; if (gnt !== 4'b0010 || gnt !== exp_gnt) begin fails++; $display("FAIL single_gnt got %b want 0010", gnt); end
        checks++; if (rand_out !== exp_out) begin fails++; $display("FAIL single_out got %h want %h", rand_out, exp_out); end
        checks++; if (rand_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", rand_valid); end
        req = '0; rand_in = 32'h0000_0012;
        step();
        checks++; if (gnt !== '0 || rand_valid !== 1'b0) begin fails++; $display("FAIL single_gap gnt=%b valid=%b want 0000/0", gnt, rand_valid); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] tbl [10];
        tbl = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            rand_in = 32'h0000_0100 + i;
            step();
            checks++;
            if (gnt !== tbl[i] || gnt !== exp_gnt) begin
                fails++; $display("FAIL rr_order[%0d] got %b want %b", i, gnt, tbl[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100; rand_in = 32'h0000_0A01;
        step();                       // grant index 2, ptr -> 3
        req = 4'b0101; rand_in = 32'h0000_0A02;
        step();                       // rest cycle
        rand_in = 32'h0000_0A03;
        step();
        checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL wrap_first got %b want 0001", gnt); end
        req = 4'b0100; rand_in = 32'h0000_0A04;
        step();
        rand_in = 32'h0000_0A05;
        step();
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL wrap_second got %b want 0100", gnt); end
    endtask

    task automatic test_stale();
        do_reset();
        req = 4'b0001; rand_in = 32'h1234_5678;
        step();
        checks++; if (gnt !== 4'b0001 || rand_out !== exp_out) begin fails++; $display("FAIL stale_first gnt=%b out=%h want 0001/%h", gnt, rand_out, exp_out); end
        step();                       // rest cycle, still no stall
        checks++; if (stall !== 1'b0) begin fails++; $display("FAIL stale_rest_stall got %b want 0", stall); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== '0 || stall !== 1'b1) begin
                fails++; $display("FAIL stale_block[%0d] gnt=%b stall=%b want 0000/1", i, gnt, stall);
            end
        end
        rand_in = 32'h1234_5679;
        step();
        checks++; if (gnt !== 4'b0001 || stall !== 1'b0) begin fails++; $display("FAIL stale_release gnt=%b stall=%b want 0001/0", gnt, stall); end
        checks++; if (rand_out !== exp_out) begin fails++; $display("FAIL stale_release_out got %h want %h", rand_out, exp_out); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0001; rand_in = 32'h0000_0C01;
        step();                       // index 0, ptr -> 1
        req = 4'b0100; rand_in = 32'h0000_0C02;
        step();
        rand_in = 32'h0000_0C03;
        step();                       // index 2, ptr -> 3
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_pre got %b want 0100", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== '0 || rand_valid !== 1'b0) begin fails++; $display("FAIL midrst_gnt gnt=%b valid=%b want 0000/0", gnt, rand_valid); end
        checks++; if (rand_out !== 32'h0) begin fails++; $display("FAIL midrst_out got %h want 0", rand_out); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Requester 2 still pending plus requester 3: a stale ptr of 3
        // would pick index 3, a cleared ptr picks index 2.
        req = 4'b1100; rand_in = 32'h0000_0C04;
        step();
        checks++; if (gnt !== 4'b0100 || gnt !== exp_gnt) begin fails++; $display("FAIL midrst_after got %b want 0100", gnt); end
    endtask

    task automatic test_whiten();
        do_reset();
        req = 4'b0001; rand_in = 32'h0000_0001;
        step();
        checks++; if (rand_out !== 32'h0000_0001) begin fails++; $display("FAIL whiten_first got %h want 00000001", rand_out); end
        rand_in = 32'h0000_0002;
        step();
        rand_in = 32'h0000_0100;
        step();
        checks++;
        if (WHITEN) begin
            if (rand_out !== 32'h0000_0180) begin fails++; $display("FAIL whiten_second got %h want 00000180", rand_out); end
        end else begin
            if (rand_out !== 32'h0000_0100) begin fails++; $display("FAIL plain_second got %h want 00000100", rand_out); end
        end
    endtask

    task automatic test_random();
        logic [31:0] prev_out;
        bit          have_prev;
        do_reset();
        req = '0;
        have_prev = 1'b0;
        prev_out  = '0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r] && $urandom_range(0, 3) == 0) req[r] = 1'b1;
            end
            if ($urandom_range(0, 5) != 0) rand_in = $urandom;
            step();
            checks++;
            if (gnt !== exp_gnt || stall !== exp_stall || rand_out !== exp_out
                || rand_valid !== (exp_gnt != '0)) begin
                fails++;
                $display("FAIL rand[%0d] gnt=%b stall=%b out=%h want %b/%b/%h",
                         n, gnt, stall, rand_out, exp_gnt, exp_stall, exp_out);
            end
            if (!$onehot0(gnt)) begin
                fails++; $display("FAIL rand_onehot[%0d] gnt=%b want one-hot or zero", n, gnt);
            end
            if (exp_gnt != '0) begin
                if (have_prev && rand_out === prev_out) begin
                    fails++; $display("FAIL rand_repeat[%0d] out=%h equals previous grant", n, rand_out);
                end
                prev_out  = rand_out;
                have_prev = 1'b1;
                req = req & ~exp_gnt;
            end
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        rst_n   = 1'b0;
        req     = '0;
        rand_in = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stale();
        test_reset_mid_grant();
        test_whiten();
        test_random();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
